// File: rtl/uart_pkg.sv
// Shared RS-232 frame definitions used by the transmitter and receiver.
// Holds the TX state encoding and the frame-level constants.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the RS-232 transmitter.
// Occupancy is held in its own register; pointers wrap at the power-of-two depth.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = UART_DATA_BITS
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  // A push into a full FIFO is dropped; a pop from an empty one is ignored.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/rs232_tx.sv
// RS-232 transmitter: buffered bytes are sent LSB first as start, 8 data, stop bit(s).
// The serial line is registered and driven from the next-state so a pop shows up at once.
module rs232_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 4,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [UART_DATA_BITS-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        out_ready,
  output logic                        out_serial,
  output logic                        out_busy,
  output logic [$clog2(FIFO_DEPTH):0] out_fifo_count
);

  localparam int unsigned CntW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast  = CntW'(CLOCKS_PER_BIT - 1);
  localparam logic [2:0]      DataLast = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [CntW-1:0]           cycle_cnt_q, cycle_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      serial_q, serial_d;

  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      bit_done;

  uart_tx_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(UART_DATA_BITS)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (resetn),
    .push_i (in_valid),
    .data_i (in_data),
    .pop_i  (fifo_pop),
    .data_o (fifo_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(out_fifo_count)
  );

  assign bit_done   = (cycle_cnt_q == CntLast);
  assign out_ready  = ~fifo_full;
  assign out_serial = serial_q;
  assign out_busy   = (state_q != IDLE) | ~fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cycle_cnt_q <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      serial_q    <= UART_IDLE_LEVEL;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      serial_q    <= serial_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cycle_cnt_d = '0;
        bit_idx_d   = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          state_d  = START;
        end
      end
      START: begin
        cycle_cnt_d = bit_done ? '0 : cycle_cnt_q + 1'b1;
        if (bit_done) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        cycle_cnt_d = bit_done ? '0 : cycle_cnt_q + 1'b1;
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == DataLast) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        cycle_cnt_d = bit_done ? '0 : cycle_cnt_q + 1'b1;
        // bit_idx counts stop bits here; the next frame starts with no idle gap.
        if (bit_done) begin
          if (bit_idx_q == StopLast) begin
            bit_idx_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_data;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    serial_d = UART_IDLE_LEVEL;
    unique case (state_d)
      START:   serial_d = ~UART_IDLE_LEVEL;
      DATA:    serial_d = shift_d[0];
      default: serial_d = UART_IDLE_LEVEL;
    endcase
  end

endmodule
